// File: rtl/vls_pkg.sv
// Shared definitions for the vector load/store unit.
// Holds the RISC-V opcodes for vector loads and stores, the FSM state
// encoding, and the helpers that size the beat counter.
package vls_pkg;

  localparam logic [6:0] OP_VLOAD  = 7'b0000111;
  localparam logic [6:0] OP_VSTORE = 7'b0100111;

  typedef enum logic [2:0] {
    IDLE,
    LD_REQ,
    LD_WAIT,
    ST_REQ,
    DONE
  } state_e;

  function automatic int nbeat(input int vlen, input int beat_w);
    return vlen / beat_w;
  endfunction

  // Beat counter width; a single-beat register still needs one bit.
  function automatic int beat_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vls_vreg_unit_if.sv
// Memory beat bus between the vector load/store unit and memory.
//   mem_req_valid/ready : request handshake, one beat per transfer
//   mem_req_we          : 1 = store beat, 0 = load beat
//   mem_req_addr        : beat byte address
//   mem_req_wdata       : store beat data
//   mem_resp_valid      : load beat data valid (no backpressure)
//   mem_resp_rdata      : load beat data
// master = unit side, slave = memory side.
interface vls_vreg_unit_if #(
  parameter int ADDR_W = 64,
  parameter int BEAT_W = 256
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [BEAT_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [BEAT_W-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/vls_vreg_file.sv
// Vector register file: NREG registers of VLEN bits, stored as NBEAT beats.
//   clock, reset         : clock, synchronous active-high clear of all registers
//   wr_en_i/idx/beat/data: beat-granular write port
//   st_idx_i/st_beat_i   : beat-granular combinational read (store data)
//   st_data_o            : selected beat
//   rd_idx_i/rd_data_o   : full-width combinational read; out-of-range reads 0
module vls_vreg_file
  import vls_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int VLEN   = 1024,
  parameter int BEAT_W = 256
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      wr_en_i,
  input  logic [4:0]                                wr_idx_i,
  input  logic [beat_idx_w(nbeat(VLEN, BEAT_W))-1:0] wr_beat_i,
  input  logic [BEAT_W-1:0]                         wr_data_i,
  input  logic [4:0]                                st_idx_i,
  input  logic [beat_idx_w(nbeat(VLEN, BEAT_W))-1:0] st_beat_i,
  output logic [BEAT_W-1:0]                         st_data_o,
  input  logic [4:0]                                rd_idx_i,
  output logic [VLEN-1:0]                           rd_data_o
);

  localparam int NBEAT = nbeat(VLEN, BEAT_W);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [NBEAT-1:0][BEAT_W-1:0] regs_q [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wr_en_i && (int'(wr_idx_i) < NREG)) begin
      regs_q[wr_idx_i[IDX_W-1:0]][wr_beat_i] <= wr_data_i;
    end
  end

  always_comb begin
    st_data_o = regs_q[st_idx_i[IDX_W-1:0]][st_beat_i];
    rd_data_o = '0;
    if (int'(rd_idx_i) < NREG) rd_data_o = regs_q[rd_idx_i[IDX_W-1:0]];
  end

endmodule

// File: rtl/vls_vreg_unit.sv
// Vector load/store unit: decodes unit-stride vector loads/stores and moves
// one VLEN-bit register between memory and the register file in NBEAT beats.
//   clock, reset        : clock, synchronous active-high reset
//   instr_valid/ready   : instruction handshake (ready only in IDLE)
//   instr, base_addr    : instruction word and rs1 value, sampled on accept
//   mem                 : memory beat bus (master side)
//   done/_is_store/_vd  : one-cycle completion pulse and qualifiers
//   illegal             : one-cycle pulse after accepting an unsupported access
//   rd_idx/rd_data      : combinational checker read port
module vls_vreg_unit
  import vls_pkg::*;
#(
  parameter int VLEN   = 1024,
  parameter int NREG   = 32,
  parameter int BEAT_W = 256,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              instr_ready,
  vls_vreg_unit_if.master   mem,
  output logic              done,
  output logic              done_is_store,
  output logic [4:0]        done_vd,
  output logic              illegal,
  input  logic [4:0]        rd_idx,
  output logic [VLEN-1:0]   rd_data
);

  localparam int NBEAT      = nbeat(VLEN, BEAT_W);
  localparam int BW         = beat_idx_w(NBEAT);
  localparam int BEAT_BYTES = BEAT_W / 8;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEAT - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        vd_q, vd_d;
  logic              st_q, st_d;
  logic              illegal_q, illegal_d;

  logic              is_ld, is_st, bad;
  logic              wr_en;
  logic [BEAT_W-1:0] st_data;
  logic              unused_instr_bits;

  assign is_ld = (instr[6:0] == OP_VLOAD)  && instr[14];
  assign is_st = (instr[6:0] == OP_VSTORE) && instr[14];
  assign bad   = (instr[27:26] != 2'b00) || !instr[25] || (int'(instr[11:7]) >= NREG);
  assign unused_instr_bits = ^{instr[31:28], instr[24:15], instr[13:12]};

  vls_vreg_file #(
    .NREG   (NREG),
    .VLEN   (VLEN),
    .BEAT_W (BEAT_W)
  ) u_vreg_file (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_idx_i  (vd_q),
    .wr_beat_i (beat_q),
    .wr_data_i (mem.mem_resp_rdata),
    .st_idx_i  (vd_q),
    .st_beat_i (beat_q),
    .st_data_o (st_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      vd_q      <= '0;
      st_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      vd_q      <= vd_d;
      st_q      <= st_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    beat_d            = beat_q;
    addr_d            = addr_q;
    vd_d              = vd_q;
    st_d              = st_q;
    illegal_d         = 1'b0;
    instr_ready       = 1'b0;
    wr_en             = 1'b0;
    done              = 1'b0;
    done_is_store     = 1'b0;
    done_vd           = '0;
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    // Address is a register, so it is stable for the whole request.
    mem.mem_req_addr  = addr_q;
    mem.mem_req_wdata = (state_q == ST_REQ) ? st_data : '0;

    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && (is_ld || is_st)) begin
          if (bad) begin
            illegal_d = 1'b1;
          end else begin
            vd_d    = instr[11:7];
            addr_d  = base_addr;
            beat_d  = '0;
            st_d    = is_st;
            state_d = is_st ? ST_REQ : LD_REQ;
          end
        end
      end
      LD_REQ: begin
        mem.mem_req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem.mem_resp_valid) begin
          wr_en = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            addr_d  = addr_q + ADDR_W'(BEAT_BYTES);
            state_d = LD_REQ;
          end
        end
      end
      ST_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        if (mem.mem_req_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            addr_d = addr_q + ADDR_W'(BEAT_BYTES);
          end
        end
      end
      DONE: begin
        done          = 1'b1;
        done_is_store = st_q;
        done_vd       = vd_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_vls_vreg_unit.sv
// Directed bench for vls_vreg_unit (VLEN=1024, BEAT_W=256, NBEAT=4) with a
// reactive memory model offering stall and response-delay knobs.
module tb_vls_vreg_unit;
  import vls_pkg::*;

  localparam int VLEN   = 1024;
  localparam int NREG   = 32;
  localparam int BEAT_W = 256;
  localparam int ADDR_W = 64;

  logic              clock;
  logic              reset;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] base_addr;
  logic              instr_ready;
  logic              done;
  logic              done_is_store;
  logic [4:0]        done_vd;
  logic              illegal;
  logic [4:0]        rd_idx;
  logic [VLEN-1:0]   rd_data;

  vls_vreg_unit_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) mem_bus ();

  vls_vreg_unit #(
    .VLEN   (VLEN),
    .NREG   (NREG),
    .BEAT_W (BEAT_W),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .base_addr     (base_addr),
    .instr_ready   (instr_ready),
    .mem           (mem_bus),
    .done          (done),
    .done_is_store (done_is_store),
    .done_vd       (done_vd),
    .illegal       (illegal),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data)
  );

  typedef struct {
    int          cyc;
    logic [63:0] addr;
    logic        we;
    logic [255:0] wdata;
  } req_t;

  typedef struct {
    int       cyc;
    logic     st;
    logic [4:0] vd;
  } done_t;

  int     cyc;
  int     n_checks;
  int     n_errors;
  req_t   reqs[$];
  done_t  dones[$];
  int     ills[$];
  int     vcyc;

  logic [63:0] stall_addr;
  int          stall_left;
  logic [63:0] delay_addr;
  int          delay;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int k);
    logic [31:0] w;
    w = 32'hA0 + 32'(k);
    return {8{w}};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] vd,
                                     input logic [1:0] mop, input logic vm, input logic w14);
    return {3'b000, 1'b0, mop, vm, 5'b00000, 5'b00001, w14, 2'b10, vd, op};
  endfunction

  // Memory model and bus monitor; everything happens mid-cycle on negedge.
  initial begin
    logic pend;
    int   pend_cyc;
    logic [255:0] pend_data;
    logic prev_stall;
    pend = 1'b0; pend_cyc = 0; pend_data = '0; prev_stall = 1'b0;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clock);
      if (pend && pend_cyc == cyc) begin
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = pend_data;
        pend = 1'b0;
      end else begin
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;
      end
      if (prev_stall) begin
        chk("req_hold_valid", 256'(mem_bus.mem_req_valid), 256'(1));
        chk("req_hold_addr", 256'(mem_bus.mem_req_addr), 256'(stall_addr));
        chk("req_hold_we", 256'(mem_bus.mem_req_we), 256'(0));
      end
      if (done) dones.push_back('{cyc, done_is_store, done_vd});
      if (illegal) ills.push_back(cyc);
      if (mem_bus.mem_req_valid) begin
        vcyc++;
        if (mem_bus.mem_req_addr == stall_addr && stall_left > 0) begin
          mem_bus.mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_bus.mem_req_ready = 1'b1;
        end
      end else begin
        mem_bus.mem_req_ready = 1'b1;
      end
      prev_stall = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
      if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        reqs.push_back('{cyc, mem_bus.mem_req_addr, mem_bus.mem_req_we, mem_bus.mem_req_wdata});
        if (!mem_bus.mem_req_we) begin
          pend      = 1'b1;
          pend_cyc  = cyc + 1 + ((mem_bus.mem_req_addr == delay_addr) ? delay : 0);
          pend_data = pat(int'(mem_bus.mem_req_addr[6:5]));
        end
      end
    end
  end

  task automatic clear_logs();
    reqs.delete();
    dones.delete();
    ills.delete();
    vcyc = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [63:0] base, output int t);
    int n;
    n = 0;
    while (!instr_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("issue_ready", 256'(instr_ready), 256'(1));
    instr_valid = 1'b1;
    instr       = ins;
    base_addr   = base;
    t           = cyc;
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (dones.size() == 0 && n < lim) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_done(input string tag, input int exp_cyc, input logic st, input logic [4:0] vd);
    chk({tag, "_ndone"}, 256'(dones.size()), 256'(1));
    if (dones.size() > 0) begin
      chk({tag, "_done_cyc"}, 256'(dones[0].cyc), 256'(exp_cyc));
      chk({tag, "_done_st"}, 256'(dones[0].st), 256'(st));
      chk({tag, "_done_vd"}, 256'(dones[0].vd), 256'(vd));
    end
  endtask

  task automatic chk_reqs(input string tag, input logic [63:0] base, input logic we, input int cy [4]);
    chk({tag, "_nreq"}, 256'(reqs.size()), 256'(4));
    for (int k = 0; k < 4 && k < reqs.size(); k++) begin
      chk({tag, "_req_cyc"}, 256'(reqs[k].cyc), 256'(cy[k]));
      chk({tag, "_req_addr"}, 256'(reqs[k].addr), 256'(base + 64'(32 * k)));
      chk({tag, "_req_we"}, 256'(reqs[k].we), 256'(we));
      if (we) chk({tag, "_req_wdata"}, reqs[k].wdata, pat(k));
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic zero);
    rd_idx = 5'(idx);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk(tag, rd_data[k*256 +: 256], zero ? 256'(0) : pat(k));
    end
  endtask

  initial begin
    int t;
    int n;
    n_checks = 0; n_errors = 0; vcyc = 0;
    stall_addr = '1; stall_left = 0; delay_addr = '1; delay = 0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0; base_addr = '0; rd_idx = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    chk("rst_instr_ready", 256'(instr_ready), 256'(1));
    chk("rst_req_valid", 256'(mem_bus.mem_req_valid), 256'(0));
    chk("rst_req_we", 256'(mem_bus.mem_req_we), 256'(0));
    chk("rst_done", 256'({done, done_is_store, done_vd}), 256'(0));
    chk("rst_illegal", 256'(illegal), 256'(0));
    for (int i = 0; i < 32; i++) chk_reg("rst_vreg_zero", i, 1'b1);

    // Zero-wait load, vd=5
    clear_logs();
    issue(mk(OP_VLOAD, 5'd5, 2'b00, 1'b1, 1'b1), 64'h1000, t);
    wait_done(60);
    chk_reqs("ld5", 64'h1000, 1'b0, '{t + 1, t + 3, t + 5, t + 7});
    chk_done("ld5", t + 9, 1'b0, 5'd5);
    chk_reg("ld5_vreg", 5, 1'b0);

    // Zero-wait store of vs3=5
    clear_logs();
    issue(mk(OP_VSTORE, 5'd5, 2'b00, 1'b1, 1'b1), 64'h2000, t);
    wait_done(60);
    chk_reqs("st5", 64'h2000, 1'b1, '{t + 1, t + 2, t + 3, t + 4});
    chk_done("st5", t + 5, 1'b1, 5'd5);

    // Backpressure: beat 2 stalled 3 cycles, its response 2 cycles late
    clear_logs();
    stall_addr = 64'h3040; stall_left = 3; delay_addr = 64'h3040; delay = 2;
    issue(mk(OP_VLOAD, 5'd7, 2'b00, 1'b1, 1'b1), 64'h3000, t);
    wait_done(80);
    chk_reqs("bp7", 64'h3000, 1'b0, '{t + 1, t + 3, t + 8, t + 12});
    chk_done("bp7", t + 14, 1'b0, 5'd7);
    chk("bp7_valid_cycles", 256'(vcyc), 256'(7));
    chk_reg("bp7_vreg", 7, 1'b0);
    chk_reg("bp7_vreg5_kept", 5, 1'b0);
    stall_addr = '1; delay_addr = '1; delay = 0;

    // Illegal accesses: mop=01, then vm=0; then a scalar load (ignored)
    clear_logs();
    issue(mk(OP_VLOAD, 5'd9, 2'b01, 1'b1, 1'b1), 64'h4000, t);
    repeat (4) @(negedge clock);
    chk("ill_mop_count", 256'(ills.size()), 256'(1));
    if (ills.size() > 0) chk("ill_mop_cyc", 256'(ills[0]), 256'(t + 1));
    issue(mk(OP_VSTORE, 5'd10, 2'b00, 1'b0, 1'b1), 64'h4000, t);
    repeat (4) @(negedge clock);
    chk("ill_vm_count", 256'(ills.size()), 256'(2));
    if (ills.size() > 1) chk("ill_vm_cyc", 256'(ills[1]), 256'(t + 1));
    issue(mk(OP_VLOAD, 5'd11, 2'b00, 1'b1, 1'b0), 64'h4000, t);
    repeat (4) @(negedge clock);
    chk("ign_ill_count", 256'(ills.size()), 256'(2));
    chk("ill_no_req", 256'(vcyc), 256'(0));
    chk("ill_no_done", 256'(dones.size()), 256'(0));
    chk_reg("ill_vreg9", 9, 1'b1);
    chk_reg("ill_vreg11", 11, 1'b1);

    // Legal load to the top register
    clear_logs();
    issue(mk(OP_VLOAD, 5'd31, 2'b00, 1'b1, 1'b1), 64'h5000, t);
    wait_done(60);
    chk_reqs("ld31", 64'h5000, 1'b0, '{t + 1, t + 3, t + 5, t + 7});
    chk_done("ld31", t + 9, 1'b0, 5'd31);
    chk_reg("ld31_vreg", 31, 1'b0);

    // Reset in LD_WAIT of beat 2; stale response lands the cycle after
    clear_logs();
    delay_addr = 64'h6040; delay = 1;
    issue(mk(OP_VLOAD, 5'd3, 2'b00, 1'b1, 1'b1), 64'h6000, t);
    n = 0;
    while (cyc < t + 6 && n < 50) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    delay_addr = '1; delay = 0;
    chk("mrst_instr_ready", 256'(instr_ready), 256'(1));
    chk("mrst_no_done", 256'(dones.size()), 256'(0));
    chk("mrst_nreq", 256'(reqs.size()), 256'(3));
    chk("mrst_req_valid", 256'(mem_bus.mem_req_valid), 256'(0));
    for (int i = 0; i < 32; i++) chk_reg("mrst_vreg_zero", i, 1'b1);

    // Normal load after mid-operation reset
    clear_logs();
    issue(mk(OP_VLOAD, 5'd3, 2'b00, 1'b1, 1'b1), 64'h7000, t);
    wait_done(60);
    chk_reqs("ld3", 64'h7000, 1'b0, '{t + 1, t + 3, t + 5, t + 7});
    chk_done("ld3", t + 9, 1'b0, 5'd3);
    chk_reg("ld3_vreg", 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vls_vreg_unit.md
Name: vls_vreg_unit

Overview:
Parametrised vector load/store unit for the softmax test harness. It decodes unit-stride vector load and store instructions, moves one VLEN-bit register between the memory port and an internal NREG-entry vector register file as NBEAT = VLEN/BEAT_W beats, and exposes a combinational read port for the checker. It replaces the single-cycle whole-register load model with a handshaked, multi-beat, load-and-store datapath.

Parameters:
VLEN, 1024, bits per vector register
NREG, 32, number of vector registers (power of 2, ≤32)
BEAT_W, 256, memory beat width; VLEN % BEAT_W == 0
ADDR_W, 64, memory address width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr  in  32  RISC-V instruction word
base_addr  in  ADDR_W  rs1 value, sampled on accept
instr_ready  out  1  unit can accept an instruction
mem_req_valid  out  1  memory beat request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = store beat
mem_req_addr  out  ADDR_W  beat byte address
mem_req_wdata  out  BEAT_W  store beat data
mem_resp_valid  in  1  load beat data valid
mem_resp_rdata  in  BEAT_W  load beat data
done  out  1  one-cycle pulse, instruction complete
done_is_store  out  1  qualifies done
done_vd  out  5  register index of completed instruction
illegal  out  1  one-cycle pulse, unsupported vector access
rd_idx  in  5  checker read index
rd_data  out  VLEN  vreg[rd_idx], combinational

Behaviour:
- Reset: all NREG registers cleared to 0. State IDLE. instr_ready=1 after reset deasserts. All other outputs 0.
- Accept: instr_valid && instr_ready. instr_ready=1 only in IDLE.
- Decode: opcode 0000111 = load; 0100111 = store. The vector qualifier is instr[14]==1. vd/vs3 = instr[11:7].
- Any other opcode, or instr[14]==0: accepted and ignored. No done, no illegal.
- Vector access with mop instr[27:26]!=00, vm instr[25]==0, or vd≥NREG: illegal pulses the cycle after accept. State stays IDLE and vreg is untouched.
- Addressing: beat k (0..NBEAT-1) has address base_addr + k*(BEAT_W/8), modulo 2^ADDR_W. Beat k maps to vreg bits [k*BEAT_W +: BEAT_W].
- FSM states:
  - IDLE -> LD_REQ or ST_REQ on a legal accept.
  - LD_REQ: mem_req_valid=1, we=0. On mem_req_ready go to LD_WAIT.
  - LD_WAIT: on mem_resp_valid, write the beat at the clock edge. Then go to LD_REQ for the next beat, or to DONE after the last beat.
  - ST_REQ: mem_req_valid=1, we=1, wdata = current vreg slice. On mem_req_ready, advance the beat. After the last beat, go to DONE. Stores receive no response.
  - DONE: done=1 with done_is_store and done_vd, then go to IDLE.
- At most one load request is outstanding.
- mem_resp_valid is ignored outside LD_WAIT, including the response to a request killed by reset.
- Request stability: once mem_req_valid rises, addr, we and wdata hold until mem_req_ready is seen.
- Latency with zero-wait memory (resp one cycle after req accept), accept at cycle T:
  - Load, NBEAT=4: requests at T+1, T+3, T+5, T+7. done at T+9.
  - Store, NBEAT=4: requests at T+1..T+4. done at T+5.
- rd_data reflects a beat write from the cycle after the response cycle.
- Reset mid-operation: returns to IDLE and clears vreg. Partial loads are discarded and no done is issued.
- A single-beat configuration (VLEN==BEAT_W) must work. The beat counter width is max(1, clog2(NBEAT)).

Decomposition:
- Package vls_pkg holds:
  - opcode constants OP_VLOAD and OP_VSTORE;
  - the state enum (IDLE, LD_REQ, LD_WAIT, ST_REQ, DONE);
  - a function nbeat(VLEN, BEAT_W).
- Sub-module vls_vreg_file(NREG, VLEN, BEAT_W) provides:
  - synchronous reset clear;
  - one beat-granular write port (idx, beat, data, en);
  - one beat-granular combinational read port for store data;
  - one full-width combinational read port for the checker.
- The FSM, decode and address generation stay in vls_vreg_unit.

Test Plan:
- Reset, then read all rd_idx 0..31 -> rd_data=0 for each; instr_ready=1.
- vle vd=5 (instr 0x0200_E287-class encoding, mop=00, vm=1), base=0x1000, zero-wait memory returning beat k = {8{32'hA0+k}} -> addresses 0x1000/0x1020/0x1040/0x1060; done at T+9 with done_vd=5 and done_is_store=0; rd_data(5) holds the pattern.
- vse vs3=5 after the above, base=0x2000 -> four we=1 requests at 0x2000..0x2060 with wdata matching the loaded beats; done at T+5 with done_is_store=1.
- Backpressure: mem_req_ready low 3 cycles on beat 2 of a load, and response delayed 2 cycles -> addr stable while stalled, no extra requests, done delayed by exactly 5 cycles, data correct.
- vle with mop=01 -> illegal pulse at T+1, no mem_req_valid, vreg unchanged; a following legal vle to vd=31 completes and writes vreg[31].
- Reset asserted in LD_WAIT after beat 1, with a stale mem_resp_valid on the cycle after reset -> vreg all zero, no done, IDLE with instr_ready=1; the next vle completes normally.
